decode_regfile: RTL and testbench

Parametrised decode stage for the Y86 core with an integrated, writable register file and a registered decode output. It derives source and destination register IDs from `icode`/`rA`/`rB`, reads two operands, and accepts two write-back ports (`valE`, `valM`) from later stages. Results are held in a valid/ready output register, so the block can sit between fetch and execute in both the single-cycle and the pipelined builds.

---
 rtl/y86_pkg.sv | 79 +++++++
 rtl/regfile_2r2w.sv | 76 +++++++
 rtl/decode_regfile.sv | 97 +++++++++
 tb/tb_decode_regfile.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, special register IDs and the
// register-ID decode tables used by the decode stage.
package y86_pkg;

    typedef logic [3:0] reg_id_t;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVQ  = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RRSP  = 4'h4;

    typedef struct packed {
        reg_id_t src_a;
        reg_id_t src_b;
        reg_id_t dst_e;
        reg_id_t dst_m;
    } dec_ids_t;

    // Source/destination selection; anything not listed uses RNONE.
    function automatic dec_ids_t decode_ids(logic [3:0] icode, reg_id_t ra, reg_id_t rb);
        dec_ids_t ids;
        ids = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
        case (icode)
            ICMOVQ, IOPQ: begin
                ids.src_a = ra;
                ids.src_b = rb;
                ids.dst_e = rb;
            end
            IIRMOVQ: begin
                ids.src_a = ra;
                ids.src_b = rb;
                ids.dst_e = rb;
            end
            IRMMOVQ: begin
                ids.src_a = ra;
                ids.src_b = rb;
            end
            IMRMOVQ: begin
                ids.src_a = ra;
                ids.src_b = rb;
                ids.dst_m = ra;
            end
            ICALL: begin
                ids.src_b = RRSP;
                ids.dst_e = RRSP;
            end
            IRET: begin
                ids.src_a = RRSP;
                ids.src_b = RRSP;
                ids.dst_e = RRSP;
            end
            IPUSHQ: begin
                ids.src_a = ra;
                ids.src_b = RRSP;
                ids.dst_e = RRSP;
            end
            IPOPQ: begin
                ids.src_a = RRSP;
                ids.src_b = RRSP;
                ids.dst_e = RRSP;
                ids.dst_m = ra;
            end
            default: ;
        endcase
        return ids;
    endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Register file with two combinational read ports and two write ports
// (valM has priority over valE on the same register). IDs at or above
// REG_NUM read as zero and are never written.
// Optional feature macro: DECODE_WB_BYPASS_EN forwards same-cycle write data
// onto the read ports.
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int REG_NUM = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  reg_id_t           i_raddr_a,
    input  reg_id_t           i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we_e,
    input  reg_id_t           i_waddr_e,
    input  logic [DATA_W-1:0] i_wdata_e,
    input  logic              i_we_m,
    input  reg_id_t           i_waddr_m,
    input  logic [DATA_W-1:0] i_wdata_m
);

    logic [DATA_W-1:0] r_regs [REG_NUM];
    reg_id_t           w_raddr [2];

    assign w_raddr[0] = i_raddr_a;
    assign w_raddr[1] = i_raddr_b;

    // Storage update: valM overrides valE when both hit the same register.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < REG_NUM; i++) begin
            if (!rst_n_i) begin
                r_regs[i] <= '0;
            end else if (i_we_m && i_waddr_m == 4'(i)) begin
                r_regs[i] <= i_wdata_m;
            end else if (i_we_e && i_waddr_e == 4'(i)) begin
                r_regs[i] <= i_wdata_e;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] w_val;
`ifdef DECODE_WB_BYPASS_EN
            localparam logic [4:0] LP_REG_NUM = 5'(REG_NUM);
`endif
            // Read mux; unmatched IDs (RNONE or out of range) return zero.
            always_comb begin
                w_val = '0;
                for (int i = 0; i < REG_NUM; i++) begin
                    if (w_raddr[gi] == 4'(i)) begin
                        w_val = r_regs[i];
                    end
                end
`ifdef DECODE_WB_BYPASS_EN
                if ({1'b0, w_raddr[gi]} < LP_REG_NUM) begin
                    if (i_we_m && i_waddr_m == w_raddr[gi]) begin
                        w_val = i_wdata_m;
                    end else if (i_we_e && i_waddr_e == w_raddr[gi]) begin
                        w_val = i_wdata_e;
                    end
                end
`endif
            end
        end
    endgenerate

    assign o_rdata_a = g_rd[0].w_val;
    assign o_rdata_b = g_rd[1].w_val;

endmodule

// File: rtl/decode_regfile.sv
// Y86 decode stage: register-ID decode, operand read from the integrated
// register file, and a valid/ready output register toward execute.
// Optional feature macro: DECODE_WB_BYPASS_EN (handled in regfile_2r2w).
module decode_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int REG_NUM = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        rA_i,
    input  logic [3:0]        rB_i,
    input  logic              wbE_en_i,
    input  logic [3:0]        dstE_wb_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic              wbM_en_i,
    input  logic [3:0]        dstM_wb_i,
    input  logic [DATA_W-1:0] valM_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [3:0]        icode_o,
    output logic [3:0]        srcA_o,
    output logic [3:0]        srcB_o,
    output logic [3:0]        dstE_o,
    output logic [3:0]        dstM_o,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o
);

    dec_ids_t          w_ids;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;
    logic              w_ready;
    logic              w_load;

    logic              r_valid;
    logic [3:0]        r_icode;
    dec_ids_t          r_ids;
    logic [DATA_W-1:0] r_val_a;
    logic [DATA_W-1:0] r_val_b;

    assign w_ids   = decode_ids(icode_i, rA_i, rB_i);
    assign w_ready = !r_valid || ready_i;
    assign w_load  = valid_i && w_ready;

    regfile_2r2w #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_raddr_a (w_ids.src_a),
        .i_raddr_b (w_ids.src_b),
        .o_rdata_a (w_val_a),
        .o_rdata_b (w_val_b),
        .i_we_e    (wbE_en_i),
        .i_waddr_e (dstE_wb_i),
        .i_wdata_e (valE_i),
        .i_we_m    (wbM_en_i),
        .i_waddr_m (dstM_wb_i),
        .i_wdata_m (valM_i)
    );

    // Output register: load on handshake, drop valid when consumed, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_icode <= IHALT;
            r_ids   <= '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
            r_val_a <= '0;
            r_val_b <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_icode <= icode_i;
            r_ids   <= w_ids;
            r_val_a <= w_val_a;
            r_val_b <= w_val_b;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid;
    assign icode_o = r_icode;
    assign srcA_o  = r_ids.src_a;
    assign srcB_o  = r_ids.src_b;
    assign dstE_o  = r_ids.dst_e;
    assign dstM_o  = r_ids.dst_m;
    assign valA_o  = r_val_a;
    assign valB_o  = r_val_b;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile with a scoreboard of expected decodes.
// A second instance with REG_NUM=8 shares the stimulus to exercise
// out-of-range register IDs.
module tb_decode_regfile;

    localparam int DW = 64;

    typedef struct {
        logic [3:0]    icode;
        logic [3:0]    src_a;
        logic [3:0]    src_b;
        logic [3:0]    dst_e;
        logic [3:0]    dst_m;
        logic [DW-1:0] val_a;
        logic [DW-1:0] val_b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          valid_i;
    logic          ready_i;
    logic [3:0]    icode_i, rA_i, rB_i;
    logic          wbE_en_i, wbM_en_i;
    logic [3:0]    dstE_wb_i, dstM_wb_i;
    logic [DW-1:0] valE_i, valM_i;

    logic          ready_o, valid_o;
    logic [3:0]    icode_o, srcA_o, srcB_o, dstE_o, dstM_o;
    logic [DW-1:0] valA_o, valB_o;

    logic          ready8, valid8;
    logic [3:0]    icode8, srcA8, srcB8, dstE8, dstM8;
    logic [DW-1:0] valA8, valB8;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    decode_regfile #(.DATA_W(DW), .REG_NUM(15)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .wbE_en_i(wbE_en_i), .dstE_wb_i(dstE_wb_i), .valE_i(valE_i),
        .wbM_en_i(wbM_en_i), .dstM_wb_i(dstM_wb_i), .valM_i(valM_i),
        .valid_o(valid_o), .ready_i(ready_i), .icode_o(icode_o),
        .srcA_o(srcA_o), .srcB_o(srcB_o), .dstE_o(dstE_o), .dstM_o(dstM_o),
        .valA_o(valA_o), .valB_o(valB_o)
    );

    decode_regfile #(.DATA_W(DW), .REG_NUM(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready8),
        .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .wbE_en_i(wbE_en_i), .dstE_wb_i(dstE_wb_i), .valE_i(valE_i),
        .wbM_en_i(wbM_en_i), .dstM_wb_i(dstM_wb_i), .valM_i(valM_i),
        .valid_o(valid8), .ready_i(ready_i), .icode_o(icode8),
        .srcA_o(srcA8), .srcB_o(srcB8), .dstE_o(dstE8), .dstM_o(dstM8),
        .valA_o(valA8), .valB_o(valB8)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] ic, sa, sb, de, dm, input logic [DW-1:0] va, vb);
        exp_t e;
        e.icode = ic; e.src_a = sa; e.src_b = sb; e.dst_e = de; e.dst_m = dm;
        e.val_a = va; e.val_b = vb;
        sb_q.push_back(e);
    endtask

    task automatic wbe(input logic [3:0] d, input logic [DW-1:0] v);
        wbE_en_i = 1'b1; dstE_wb_i = d; valE_i = v;
    endtask

    task automatic wbm(input logic [3:0] d, input logic [DW-1:0] v);
        wbM_en_i = 1'b1; dstM_wb_i = d; valM_i = v;
    endtask

    // Apply one cycle of stimulus; write-back enables are one-shot.
    task automatic drive(input logic v, input logic [3:0] ic, ra, rb, input logic rdy);
        valid_i = v; icode_i = ic; rA_i = ra; rB_i = rb; ready_i = rdy;
        @(posedge clk);
        #1;
        wbE_en_i = 1'b0;
        wbM_en_i = 1'b0;
    endtask

    // Scoreboard: an output is consumed on the edge where valid_o && ready_i.
    always @(negedge clk) begin
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", DW'(sb_q.size()), DW'(1));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn icode=%h srcA=%h srcB=%h dstE=%h dstM=%h valA=%0h valB=%0h",
                         icode_o, srcA_o, srcB_o, dstE_o, dstM_o, valA_o, valB_o);
                chk("icode", DW'(icode_o), DW'(e.icode));
                chk("srcA",  DW'(srcA_o),  DW'(e.src_a));
                chk("srcB",  DW'(srcB_o),  DW'(e.src_b));
                chk("dstE",  DW'(dstE_o),  DW'(e.dst_e));
                chk("dstM",  DW'(dstM_o),  DW'(e.dst_m));
                chk("valA",  valA_o,       e.val_a);
                chk("valB",  valB_o,       e.val_b);
            end
        end
    end

    initial begin
        logic [DW-1:0] exp_bypass;
        rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        icode_i = 4'h0; rA_i = 4'hF; rB_i = 4'hF;
        wbE_en_i = 1'b0; wbM_en_i = 1'b0;
        dstE_wb_i = 4'hF; dstM_wb_i = 4'hF; valE_i = '0; valM_i = '0;

        // Reset
        drive(0, 4'h0, 4'hF, 4'hF, 1);
        drive(0, 4'h0, 4'hF, 4'hF, 1);
        chk("rst_valid", DW'(valid_o), DW'(0));
        chk("rst_icode", DW'(icode_o), DW'(0));
        chk("rst_srcA",  DW'(srcA_o),  DW'(4'hF));
        chk("rst_dstM",  DW'(dstM_o),  DW'(4'hF));
        chk("rst_valA",  valA_o,       DW'(0));
        chk("rst_valB",  valB_o,       DW'(0));
        rst_n_i = 1'b1;
        drive(0, 4'h0, 4'hF, 4'hF, 1);
        chk("rst_ready", DW'(ready_o), DW'(1));

        // Preload r2, r3, r4 by write-back
        wbe(4'h2, 64'h22); wbm(4'h3, 64'h33);
        drive(0, 4'h0, 4'hF, 4'hF, 1);
        wbe(4'h4, 64'h100);
        drive(0, 4'h0, 4'hF, 4'hF, 1);

        // OPQ r2,r3 and POPQ r5
        push(4'h6, 4'h2, 4'h3, 4'h3, 4'hF, 64'h22, 64'h33);
        drive(1, 4'h6, 4'h2, 4'h3, 1);
        push(4'hB, 4'h4, 4'h4, 4'h4, 4'h5, 64'h100, 64'h100);
        drive(1, 4'hB, 4'h5, 4'hF, 1);

        // Both ports write r7: valM wins
        wbe(4'h7, 64'hAA); wbm(4'h7, 64'hBB);
        drive(0, 4'h0, 4'hF, 4'hF, 1);
        push(4'h6, 4'h7, 4'h7, 4'h7, 4'hF, 64'hBB, 64'hBB);
        drive(1, 4'h6, 4'h7, 4'h7, 1);

        // Write-back of r1 in the same cycle as a load reading r1
`ifdef DECODE_WB_BYPASS_EN
        exp_bypass = 64'h55;
`else
        exp_bypass = 64'h0;
`endif
        wbe(4'h1, 64'h55);
        push(4'h2, 4'h1, 4'h2, 4'h2, 4'hF, exp_bypass, 64'h22);
        drive(1, 4'h2, 4'h1, 4'h2, 1);
        push(4'h2, 4'h1, 4'hF, 4'hF, 4'hF, 64'h55, 64'h0);
        drive(1, 4'h2, 4'h1, 4'hF, 1);

        // CALL, RET, undefined icode, MRMOVQ
        push(4'h8, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0, 64'h100);
        drive(1, 4'h8, 4'h2, 4'h3, 1);
        push(4'h9, 4'h4, 4'h4, 4'h4, 4'hF, 64'h100, 64'h100);
        drive(1, 4'h9, 4'h2, 4'h3, 1);
        push(4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0);
        drive(1, 4'hC, 4'h2, 4'h3, 1);
        push(4'h5, 4'h2, 4'h3, 4'hF, 4'h2, 64'h22, 64'h33);
        drive(1, 4'h5, 4'h2, 4'h3, 1);
        drive(0, 4'h0, 4'hF, 4'hF, 1);

        // Stall: IRMOVQ held for 3 cycles while PUSHQ waits; r6 written meanwhile
        push(4'h3, 4'hF, 4'h6, 4'h6, 4'hF, 64'h0, 64'h0);
        drive(1, 4'h3, 4'hF, 4'h6, 0);
        wbe(4'h6, 64'h66);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", DW'(ready_o), DW'(0));
            chk("stall_valid", DW'(valid_o), DW'(1));
            chk("stall_icode", DW'(icode_o), DW'(4'h3));
            chk("stall_valB",  valB_o,       DW'(0));
            drive(1, 4'hA, 4'h2, 4'hF, 0);
        end
        push(4'hA, 4'h2, 4'h4, 4'h4, 4'hF, 64'h22, 64'h100);
        drive(1, 4'hA, 4'h2, 4'hF, 1);
        chk("release_icode", DW'(icode_o), DW'(4'hA));
        drive(0, 4'h0, 4'hF, 4'hF, 1);

        // Out-of-range register on the REG_NUM=8 instance
        wbe(4'hA, 64'h99);
        drive(0, 4'h0, 4'hF, 4'hF, 1);
        push(4'h6, 4'hA, 4'h3, 4'h3, 4'hF, 64'h99, 64'h33);
        drive(1, 4'h6, 4'hA, 4'h3, 1);
        chk("r8_valA", valA8, DW'(0));
        chk("r8_valB", valB8, DW'(64'h33));
        drive(0, 4'h0, 4'hF, 4'hF, 1);

        // Reset during a stall drops the held instruction and clears registers
        drive(1, 4'h6, 4'h2, 4'h3, 0);
        chk("pre_rst_valid", DW'(valid_o), DW'(1));
        rst_n_i = 1'b0;
        drive(0, 4'h0, 4'hF, 4'hF, 0);
        chk("mid_rst_valid",  DW'(valid_o), DW'(0));
        chk("mid_rst_valid8", DW'(valid8),  DW'(0));
        chk("mid_rst_srcA",   DW'(srcA_o),  DW'(4'hF));
        rst_n_i = 1'b1;
        push(4'h6, 4'h2, 4'h3, 4'h3, 4'hF, 64'h0, 64'h0);
        drive(1, 4'h6, 4'h2, 4'h3, 1);
        drive(0, 4'h0, 4'hF, 4'hF, 1);
        drive(0, 4'h0, 4'hF, 4'hF, 1);

        chk("sb_left", DW'(sb_q.size()), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
